// File: rtl/kmkz_trap_ctrl.sv
// Machine-mode trap controller: sticky pending bits, priority select, mepc/mcause/mstatus update, eret.
// Define KMKZ_VECTORED_TRAP_EN to allow vectored interrupt dispatch via mtvec[0].
module kmkz_trap_ctrl #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [31:0] TRAP_BASE = 32'h8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  input  logic               d_is_csr_i,
  input  logic               d_is_eret_i,
  input  logic [11:0]        d_csr_sel_i,
  input  logic [31:0]        x_csr_write_value_i,
  input  logic [NUM_IRQ-1:0] exp_irq_i,
  input  logic               exp_tick_i,
  input  logic               exp_breakpoint_i,
  input  logic               exp_unaligned_load_i,
  input  logic               exp_unaligned_store_i,
  input  logic               exp_invalid_insn_i,
  input  logic [31:0]        x_exception_pc_i,
  output logic               x_exception_o,
  output logic [31:0]        x_exception_pc_o,
  output logic [31:0]        x_exception_vector_o,
  output logic [31:0]        csr_mstatus_o,
  output logic [31:0]        csr_mip_o,
  output logic [31:0]        csr_mie_o,
  output logic [31:0]        csr_mepc_o,
  output logic [31:0]        csr_mcause_o,
  output logic [31:0]        csr_mtvec_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] IRQ_MASK  = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
  localparam logic [31:0] SYNC_MASK = 32'h0000_005C;
  localparam logic [31:0] MIE_MASK  = IRQ_MASK | 32'h0000_0080;
  localparam logic [31:0] MIP_MASK  = MIE_MASK | SYNC_MASK;
`ifdef KMKZ_VECTORED_TRAP_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  logic [0:0]  state_q;
  logic [31:0] mip_q, mie_q, mepc_q, mcause_q, mtvec_q;
  logic        mstatus_mie_q, mstatus_mpie_q;

  logic        adv, trap_take, csr_wr, eret;
  logic [31:0] irq_ext, sync_set, int_set, elig_v, w1c, take_clr, mip_d, base;
  logic [4:0]  take_code;
  logic        take_irq;

  assign adv      = ~x_stall_i & ~x_kill_i;
  assign irq_ext  = 32'(exp_irq_i) << 16;
  assign sync_set = {25'b0, exp_unaligned_store_i, 1'b0, exp_unaligned_load_i,
                     exp_breakpoint_i, exp_invalid_insn_i, 2'b0};
  assign int_set  = ({24'b0, exp_tick_i, 7'b0} | irq_ext) & mie_q;

  // An illegal instruction is seen the same cycle it arrives, before it lands in mip.
  assign elig_v = (mip_q | {29'b0, exp_invalid_insn_i, 2'b0})
                & (SYNC_MASK | (mstatus_mie_q ? mie_q : 32'b0));

  always_comb begin
    take_code = 5'd0;
    take_irq  = 1'b0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (elig_v[16+k]) begin
        take_code = 5'(16 + k);
        take_irq  = 1'b1;
      end
    end
    if (elig_v[7]) begin take_code = 5'd7; take_irq = 1'b1; end
    if (elig_v[6]) begin take_code = 5'd6; take_irq = 1'b0; end
    if (elig_v[4]) begin take_code = 5'd4; take_irq = 1'b0; end
    if (elig_v[3]) begin take_code = 5'd3; take_irq = 1'b0; end
    if (elig_v[2]) begin take_code = 5'd2; take_irq = 1'b0; end
  end

  assign x_exception_o = rst_i & (state_q == ST_RUN) & (|elig_v);
  assign trap_take     = adv & x_exception_o;
  assign csr_wr        = adv & d_is_csr_i & ~trap_take;
  assign eret          = adv & d_is_eret_i & (state_q == ST_HANDLER);

  // Clearing the taken sync bit beats its source; a W1C loses to its source.
  assign w1c      = (csr_wr && d_csr_sel_i == CSR_MIP) ? x_csr_write_value_i : 32'b0;
  assign take_clr = (trap_take && !take_irq) ? (32'h1 << take_code) : 32'b0;
  assign mip_d    = (((mip_q & ~w1c) | sync_set | int_set) & ~take_clr) & MIP_MASK;

  assign base = {mtvec_q[31:2], 2'b00};
`ifdef KMKZ_VECTORED_TRAP_EN
  assign x_exception_vector_o = (mtvec_q[0] && x_exception_o && take_irq)
                              ? base + {25'b0, take_code, 2'b00} : base;
`else
  assign x_exception_vector_o = base;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= ST_RUN;
      mip_q          <= 32'b0;
      mie_q          <= 32'b0;
      mepc_q         <= 32'b0;
      mcause_q       <= 32'b0;
      mtvec_q        <= TRAP_BASE & MTVEC_MASK;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else begin
      mip_q <= mip_d;
      if (trap_take) begin
        mepc_q         <= x_exception_pc_i;
        mcause_q       <= {take_irq, 26'b0, take_code};
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        state_q        <= ST_HANDLER;
      end else begin
        if (csr_wr) begin
          case (d_csr_sel_i)
            CSR_MSTATUS: begin
              mstatus_mie_q  <= x_csr_write_value_i[3];
              mstatus_mpie_q <= x_csr_write_value_i[7];
            end
            CSR_MIE:   mie_q   <= x_csr_write_value_i & MIE_MASK;
            CSR_MEPC:  mepc_q  <= {x_csr_write_value_i[31:2], 2'b00};
            CSR_MTVEC: mtvec_q <= x_csr_write_value_i & MTVEC_MASK;
            default: ;
          endcase
        end
        if (eret) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
          state_q        <= ST_RUN;
        end
      end
    end
  end

  assign x_exception_pc_o = mepc_q;
  assign csr_mstatus_o    = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign csr_mip_o        = mip_q;
  assign csr_mie_o        = mie_q;
  assign csr_mepc_o       = mepc_q;
  assign csr_mcause_o     = mcause_q;
  assign csr_mtvec_o      = mtvec_q;

endmodule

// File: tb/tb_kmkz_trap_ctrl.sv
// Bench for kmkz_trap_ctrl: directed scenarios plus randomized traffic against a cause-list reference model.
module tb_kmkz_trap_ctrl;
  localparam int          NUM_IRQ   = 8;
  localparam logic [31:0] TRAP_BASE = 32'h8;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
                          A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MIP = 12'h344;

  logic clk_i = 1'b0, rst_i = 1'b0;
  logic x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i, x_exception_pc_i;
  logic [NUM_IRQ-1:0] exp_irq_i;
  logic exp_tick_i, exp_breakpoint_i, exp_unaligned_load_i, exp_unaligned_store_i, exp_invalid_insn_i;
  logic x_exception_o;
  logic [31:0] x_exception_pc_o, x_exception_vector_o;
  logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o, csr_mtvec_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  kmkz_trap_ctrl #(.NUM_IRQ(NUM_IRQ), .TRAP_BASE(TRAP_BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_is_csr_i(d_is_csr_i), .d_is_eret_i(d_is_eret_i), .d_csr_sel_i(d_csr_sel_i),
    .x_csr_write_value_i(x_csr_write_value_i), .exp_irq_i(exp_irq_i), .exp_tick_i(exp_tick_i),
    .exp_breakpoint_i(exp_breakpoint_i), .exp_unaligned_load_i(exp_unaligned_load_i),
    .exp_unaligned_store_i(exp_unaligned_store_i), .exp_invalid_insn_i(exp_invalid_insn_i),
    .x_exception_pc_i(x_exception_pc_i), .x_exception_o(x_exception_o),
    .x_exception_pc_o(x_exception_pc_o), .x_exception_vector_o(x_exception_vector_o),
    .csr_mstatus_o(csr_mstatus_o), .csr_mip_o(csr_mip_o), .csr_mie_o(csr_mie_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o), .csr_mtvec_o(csr_mtvec_o)
  );

  task automatic drive_idle();
    x_stall_i = 0; x_kill_i = 0; d_is_csr_i = 0; d_is_eret_i = 0; d_csr_sel_i = 0;
    x_csr_write_value_i = 0; x_exception_pc_i = 0; exp_irq_i = '0; exp_tick_i = 0;
    exp_breakpoint_i = 0; exp_unaligned_load_i = 0; exp_unaligned_store_i = 0; exp_invalid_insn_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_i = 0;
    tick(); tick();
    rst_i = 1;
    #1;
  endtask

  task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
    d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = val;
    tick();
    d_is_csr_i = 0; d_csr_sel_i = 0; x_csr_write_value_i = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    csr_write(A_MSTATUS, 32'h8);
    x_exception_pc_i = 32'h44; exp_invalid_insn_i = 1;
    tick();
    exp_invalid_insn_i = 0; #1;
    n_tests++; if (csr_mstatus_o !== 32'h80) begin n_fail++; $display("FAIL rst_pre_mstatus got %h want %h", csr_mstatus_o, 32'h80); end
    // Reset inside the handler with an illegal instruction still asserted.
    rst_i = 0; exp_invalid_insn_i = 1; #2;
    n_tests++; if (x_exception_o !== 1'b0) begin n_fail++; $display("FAIL rst_exc got %b want 0", x_exception_o); end
    n_tests++; if (x_exception_vector_o !== TRAP_BASE) begin n_fail++; $display("FAIL rst_vector got %h want %h", x_exception_vector_o, TRAP_BASE); end
    n_tests++; if (csr_mstatus_o !== 32'h0) begin n_fail++; $display("FAIL rst_mstatus got %h want 0", csr_mstatus_o); end
    n_tests++; if (csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL rst_mip got %h want 0", csr_mip_o); end
    n_tests++; if (csr_mie_o !== 32'h0) begin n_fail++; $display("FAIL rst_mie got %h want 0", csr_mie_o); end
    n_tests++; if (csr_mepc_o !== 32'h0) begin n_fail++; $display("FAIL rst_mepc got %h want 0", csr_mepc_o); end
    n_tests++; if (csr_mcause_o !== 32'h0) begin n_fail++; $display("FAIL rst_mcause got %h want 0", csr_mcause_o); end
    n_tests++; if (csr_mtvec_o !== TRAP_BASE) begin n_fail++; $display("FAIL rst_mtvec got %h want %h", csr_mtvec_o, TRAP_BASE); end
    n_tests++; if (x_exception_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc_o got %h want 0", x_exception_pc_o); end
    @(posedge clk_i); #1;
    rst_i = 1; #1;
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL rst_back_in_run got %b want 1", x_exception_o); end
    exp_invalid_insn_i = 0; #1;
  endtask

  task automatic test_illegal();
    do_reset();
    x_exception_pc_i = 32'h100; exp_invalid_insn_i = 1; #1;
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL ill_exc got %b want 1", x_exception_o); end
    n_tests++; if (x_exception_vector_o !== 32'h8) begin n_fail++; $display("FAIL ill_vector got %h want 8", x_exception_vector_o); end
    tick();
    exp_invalid_insn_i = 0; x_exception_pc_i = 32'h104; #1;
    n_tests++; if (csr_mepc_o !== 32'h100) begin n_fail++; $display("FAIL ill_mepc got %h want 100", csr_mepc_o); end
    n_tests++; if (x_exception_pc_o !== 32'h100) begin n_fail++; $display("FAIL ill_pc_o got %h want 100", x_exception_pc_o); end
    n_tests++; if (csr_mcause_o !== 32'h2) begin n_fail++; $display("FAIL ill_mcause got %h want 2", csr_mcause_o); end
    n_tests++; if (csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL ill_mip_cleared got %h want 0", csr_mip_o); end
    exp_invalid_insn_i = 1; #1;
    n_tests++; if (x_exception_o !== 1'b0) begin n_fail++; $display("FAIL ill_handler_masks got %b want 0", x_exception_o); end
    exp_invalid_insn_i = 0; #1;
  endtask

  task automatic test_irq_priority();
    logic [31:0] want_vec, want_tvec;
`ifdef KMKZ_VECTORED_TRAP_EN
    want_vec = 32'h24C; want_tvec = 32'h201;
`else
    want_vec = 32'h200; want_tvec = 32'h200;
`endif
    do_reset();
    csr_write(A_MIE, 32'h0028_0000);
    csr_write(A_MSTATUS, 32'h8);
    csr_write(A_MTVEC, 32'h201);
    n_tests++; if (csr_mtvec_o !== want_tvec) begin n_fail++; $display("FAIL irq_mtvec got %h want %h", csr_mtvec_o, want_tvec); end
    x_exception_pc_i = 32'h300; exp_irq_i = 8'b0010_1000;
    tick();
    n_tests++; if (csr_mip_o !== 32'h0028_0000) begin n_fail++; $display("FAIL irq_mip got %h want 00280000", csr_mip_o); end
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL irq_exc got %b want 1", x_exception_o); end
    n_tests++; if (x_exception_vector_o !== want_vec) begin n_fail++; $display("FAIL irq_vector got %h want %h", x_exception_vector_o, want_vec); end
    tick();
    exp_irq_i = '0; #1;
    n_tests++; if (csr_mcause_o !== 32'h8000_0013) begin n_fail++; $display("FAIL irq_mcause got %h want 80000013", csr_mcause_o); end
    n_tests++; if (csr_mepc_o !== 32'h300) begin n_fail++; $display("FAIL irq_mepc got %h want 300", csr_mepc_o); end
    n_tests++; if (csr_mstatus_o !== 32'h80) begin n_fail++; $display("FAIL irq_mstatus got %h want 80", csr_mstatus_o); end
  endtask

  task automatic test_timer_gate();
    do_reset();
    csr_write(A_MIE, 32'h80);
    exp_tick_i = 1;
    tick();
    exp_tick_i = 0; #1;
    n_tests++; if (csr_mip_o !== 32'h80) begin n_fail++; $display("FAIL tmr_mip got %h want 80", csr_mip_o); end
    n_tests++; if (x_exception_o !== 1'b0) begin n_fail++; $display("FAIL tmr_masked got %b want 0", x_exception_o); end
    tick(); tick();
    n_tests++; if (csr_mcause_o !== 32'h0) begin n_fail++; $display("FAIL tmr_no_trap got %h want 0", csr_mcause_o); end
    csr_write(A_MSTATUS, 32'h8);
    n_tests++; if (csr_mstatus_o !== 32'h8) begin n_fail++; $display("FAIL tmr_mstatus got %h want 8", csr_mstatus_o); end
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL tmr_exc got %b want 1", x_exception_o); end
    x_exception_pc_i = 32'h500;
    tick();
    n_tests++; if (csr_mcause_o !== 32'h8000_0007) begin n_fail++; $display("FAIL tmr_mcause got %h want 80000007", csr_mcause_o); end
    n_tests++; if (csr_mepc_o !== 32'h500) begin n_fail++; $display("FAIL tmr_mepc got %h want 500", csr_mepc_o); end
  endtask

  task automatic test_stall();
    do_reset();
    x_stall_i = 1; x_exception_pc_i = 32'h40; exp_invalid_insn_i = 1; #1;
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL stl_exc got %b want 1", x_exception_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_invalid_insn_i = 0; #1;
      n_tests++; if (csr_mcause_o !== 32'h0) begin n_fail++; $display("FAIL stl_mcause_%0d got %h want 0", i, csr_mcause_o); end
      n_tests++; if (csr_mepc_o !== 32'h0) begin n_fail++; $display("FAIL stl_mepc_%0d got %h want 0", i, csr_mepc_o); end
    end
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL stl_still_run got %b want 1", x_exception_o); end
    n_tests++; if (csr_mip_o !== 32'h4) begin n_fail++; $display("FAIL stl_mip got %h want 4", csr_mip_o); end
    x_stall_i = 0;
    tick();
    n_tests++; if (csr_mcause_o !== 32'h2) begin n_fail++; $display("FAIL stl_mcause got %h want 2", csr_mcause_o); end
    n_tests++; if (csr_mepc_o !== 32'h40) begin n_fail++; $display("FAIL stl_mepc got %h want 40", csr_mepc_o); end
    n_tests++; if (csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL stl_mip_clr got %h want 0", csr_mip_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    csr_write(A_MSTATUS, 32'h8);
    x_exception_pc_i = 32'h10; exp_invalid_insn_i = 1;
    tick();
    exp_invalid_insn_i = 0;
    d_is_eret_i = 1; exp_breakpoint_i = 1; #1;
    n_tests++; if (x_exception_o !== 1'b0) begin n_fail++; $display("FAIL b2b_handler got %b want 0", x_exception_o); end
    tick();
    d_is_eret_i = 0; exp_breakpoint_i = 0; x_exception_pc_i = 32'h20; #1;
    n_tests++; if (csr_mstatus_o !== 32'h88) begin n_fail++; $display("FAIL b2b_restore got %h want 88", csr_mstatus_o); end
    n_tests++; if (csr_mip_o !== 32'h8) begin n_fail++; $display("FAIL b2b_mip got %h want 8", csr_mip_o); end
    n_tests++; if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL b2b_exc got %b want 1", x_exception_o); end
    tick();
    n_tests++; if (csr_mcause_o !== 32'h3) begin n_fail++; $display("FAIL b2b_mcause got %h want 3", csr_mcause_o); end
    n_tests++; if (csr_mepc_o !== 32'h20) begin n_fail++; $display("FAIL b2b_mepc got %h want 20", csr_mepc_o); end
    n_tests++; if (csr_mstatus_o !== 32'h80) begin n_fail++; $display("FAIL b2b_mstatus got %h want 80", csr_mstatus_o); end
  endtask

  task automatic test_w1c();
    do_reset();
    csr_write(A_MIE, 32'h80);
    exp_tick_i = 1;
    tick();
    n_tests++; if (csr_mip_o !== 32'h80) begin n_fail++; $display("FAIL w1c_set got %h want 80", csr_mip_o); end
    csr_write(A_MIP, 32'h80);
    n_tests++; if (csr_mip_o !== 32'h80) begin n_fail++; $display("FAIL w1c_src_wins got %h want 80", csr_mip_o); end
    exp_tick_i = 0;
    csr_write(A_MIP, 32'h80);
    n_tests++; if (csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL w1c_clear got %h want 0", csr_mip_o); end
  endtask

  // Reference model: architectural state plus an ordered cause list.
  logic [31:0] m_mip, m_mie, m_mepc, m_mcause, m_mtvec;
  logic        m_ie, m_pie, m_handler;
  int          prio[5 + NUM_IRQ];

  function automatic int m_pick();
    for (int i = 0; i < 5 + NUM_IRQ; i++) begin
      int  code = prio[i];
      logic pend = m_mip[code] || (code == 2 && exp_invalid_insn_i);
      if (code < 7) begin
        if (pend) return code;
      end else if (pend && m_mie[code] && m_ie) begin
        return code;
      end
    end
    return -1;
  endfunction

  task automatic test_random();
    logic [11:0] sels[7];
    logic [31:0] mie_mask, src, clr, want_vec, want_st, d;
    logic        want_exc, adv, old_pie;
    int          pick;
    sels = '{A_MSTATUS, A_MIE, A_MIP, A_MEPC, A_MTVEC, A_MCAUSE, 12'h7C0};
    prio[0] = 2; prio[1] = 3; prio[2] = 4; prio[3] = 6; prio[4] = 7;
    for (int k = 0; k < NUM_IRQ; k++) prio[5 + k] = 16 + k;
    mie_mask = 32'h80 | (((32'h1 << NUM_IRQ) - 1) << 16);
    do_reset();
    m_mip = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtvec = TRAP_BASE; m_ie = 0; m_pie = 0; m_handler = 0;
    for (int c = 0; c < 3000 && n_fail < 20; c++) begin
      x_stall_i             = ($urandom_range(0, 9) < 2);
      x_kill_i              = ($urandom_range(0, 15) == 0);
      d_is_csr_i            = ($urandom_range(0, 9) < 3);
      d_csr_sel_i           = sels[$urandom_range(0, 6)];
      x_csr_write_value_i   = $urandom;
      d_is_eret_i           = ($urandom_range(0, 9) < 2);
      exp_invalid_insn_i    = ($urandom_range(0, 19) == 0);
      exp_breakpoint_i      = ($urandom_range(0, 19) == 0);
      exp_unaligned_load_i  = ($urandom_range(0, 19) == 0);
      exp_unaligned_store_i = ($urandom_range(0, 19) == 0);
      exp_tick_i            = ($urandom_range(0, 9) < 2);
      exp_irq_i             = ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : '0;
      x_exception_pc_i      = $urandom;
      #1;
      pick     = m_pick();
      want_exc = !m_handler && pick >= 0;
      want_vec = m_mtvec & 32'hFFFF_FFFC;
`ifdef KMKZ_VECTORED_TRAP_EN
      if (want_exc && pick >= 7 && m_mtvec[0]) want_vec = want_vec + 4 * pick;
`endif
      n_tests++; if (x_exception_o !== want_exc) begin n_fail++; $display("FAIL rnd_exc cyc %0d got %b want %b", c, x_exception_o, want_exc); end
      n_tests++; if (x_exception_vector_o !== want_vec) begin n_fail++; $display("FAIL rnd_vector cyc %0d got %h want %h", c, x_exception_vector_o, want_vec); end
      src = 0;
      src[2] = exp_invalid_insn_i; src[3] = exp_breakpoint_i;
      src[4] = exp_unaligned_load_i; src[6] = exp_unaligned_store_i;
      src[7] = exp_tick_i && m_mie[7];
      for (int k = 0; k < NUM_IRQ; k++) src[16 + k] = exp_irq_i[k] && m_mie[16 + k];
      adv = !x_stall_i && !x_kill_i;
      d   = x_csr_write_value_i;
      if (adv && want_exc) begin
        m_mip = m_mip | src;
        if (pick < 7) m_mip[pick] = 1'b0;
        m_mepc    = x_exception_pc_i;
        m_mcause  = 32'(pick) | ((pick >= 7) ? 32'h8000_0000 : 32'h0);
        m_pie     = m_ie; m_ie = 0; m_handler = 1;
      end else begin
        clr     = 0;
        old_pie = m_pie;
        if (adv && d_is_csr_i) begin
          case (d_csr_sel_i)
            A_MIP:     clr = d;
            A_MSTATUS: begin m_ie = d[3]; m_pie = d[7]; end
            A_MIE:     m_mie = d & mie_mask;
            A_MEPC:    m_mepc = d & 32'hFFFF_FFFC;
`ifdef KMKZ_VECTORED_TRAP_EN
            A_MTVEC:   m_mtvec = d & 32'hFFFF_FFFD;
`else
            A_MTVEC:   m_mtvec = d & 32'hFFFF_FFFC;
`endif
            default: ;
          endcase
        end
        m_mip = (m_mip & ~clr) | src;
        if (adv && d_is_eret_i && m_handler) begin
          m_ie = old_pie; m_pie = 1; m_handler = 0;
        end
      end
      want_st = (32'(m_pie) << 7) | (32'(m_ie) << 3);
      tick();
      n_tests++; if (csr_mstatus_o !== want_st) begin n_fail++; $display("FAIL rnd_mstatus cyc %0d got %h want %h", c, csr_mstatus_o, want_st); end
      n_tests++; if (csr_mip_o !== m_mip) begin n_fail++; $display("FAIL rnd_mip cyc %0d got %h want %h", c, csr_mip_o, m_mip); end
      n_tests++; if (csr_mie_o !== m_mie) begin n_fail++; $display("FAIL rnd_mie cyc %0d got %h want %h", c, csr_mie_o, m_mie); end
      n_tests++; if (csr_mepc_o !== m_mepc) begin n_fail++; $display("FAIL rnd_mepc cyc %0d got %h want %h", c, csr_mepc_o, m_mepc); end
      n_tests++; if (x_exception_pc_o !== m_mepc) begin n_fail++; $display("FAIL rnd_pc_o cyc %0d got %h want %h", c, x_exception_pc_o, m_mepc); end
      n_tests++; if (csr_mcause_o !== m_mcause) begin n_fail++; $display("FAIL rnd_mcause cyc %0d got %h want %h", c, csr_mcause_o, m_mcause); end
      n_tests++; if (csr_mtvec_o !== m_mtvec) begin n_fail++; $display("FAIL rnd_mtvec cyc %0d got %h want %h", c, csr_mtvec_o, m_mtvec); end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_illegal();
    test_irq_priority();
    test_timer_gate();
    test_stall();
    test_back_to_back();
    test_w1c();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
